reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Releases a set of downstream reset domains one at a time, in fixed order, after a power-on or system reset. It sits directly behind the reset synchronizer and is clocked in the same domain. For each stage it waits a fixed settle delay, deasserts that stage's reset, then waits for the stage to report ready before moving on. It reports completion and faults, and supports a synchronous restart of the whole sequence.

## Interface
- STAGE_COUNT, 4: number of sequenced reset domains, ≥1.
- STAGE_DELAY, 16: settle cycles before each stage's reset release, ≥1.
- TIMEOUT_CYCLES, 1024: cycles allowed for stage_ready after release, ≥1; used only when the timeout feature is compiled in.

Ports:
- clock  input  1  sole clock.
- reset  input  1  asynchronous, active-high; driven from a synchronized reset with active-high polarity.
- restart  input  1  synchronous request to reassert all stage resets and rerun the sequence.
- stage_ready  input  STAGE_COUNT  per-stage ready, synchronous to clock; bit k belongs to stage k.
- reset_out  output  STAGE_COUNT  per-stage reset, active-high; bit k drives stage k.
- sequence_done  output  1  all stages released and ready.
- fault  output  1  sequence aborted; cleared only by restart or reset.

## Operation
- States: DELAY, WAIT_READY, DONE, FAULT. A stage index idx (0..STAGE_COUNT-1) and one shared down-counter are held alongside the state.
- Reset asserted, asynchronously:
  - reset_out all ones; sequence_done=0; fault=0.
  - State=DELAY, idx=0, counter=STAGE_DELAY.
- DELAY:
  - The counter decrements each cycle.
  - When it reaches 1, the next edge clears reset_out[idx] and enters WAIT_READY, with counter=TIMEOUT_CYCLES.
- WAIT_READY, stage_ready[idx]=1 sampled:
  - If idx=STAGE_COUNT-1, go to DONE.
  - Otherwise idx+1, counter=STAGE_DELAY, go to DELAY.
- DONE:
  - sequence_done=1.
  - If any stage_ready bit drops, go to FAULT.
- FAULT:
  - reset_out all ones, sequence_done=0, fault=1.
  - The block stays here until restart.
- restart=1, any state: has priority over every other transition. Its effect matches reset except that it is synchronous and fault clears on the same edge. If held high, the block stays in DELAY with idx=0 and counter reloaded until restart falls.
- stage_ready bits for stages not yet released are ignored.
- In WAIT_READY, a ready drop on an already-released stage is ignored; only DONE checks ready drops.
- Released stages stay released, with reset_out low, until FAULT, restart or reset.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- reset_out[0] falls on exactly the STAGE_DELAY-th rising edge after the first edge at which reset is sampled low.
- stage_ready[k] sampled high at edge n:
  - reset_out[k+1] falls at edge n+STAGE_DELAY.
  - For the last stage, sequence_done rises at edge n+1.
- restart sampled high at edge n:
  - reset_out is all ones and fault=0 after edge n.
  - The first release occurs STAGE_DELAY edges after the first edge with restart low.
- Counter width is $clog2(max(STAGE_DELAY,TIMEOUT_CYCLES)+1). There is no wrap-around: the counter reloads on every state entry.

## Configuration
- RESET_SEQUENCER_TIMEOUT_EN defined:
  - In WAIT_READY the counter decrements.
  - If it reaches 1 without ready, the next edge enters FAULT. That is TIMEOUT_CYCLES cycles after release.
  - Ready sampled on the same edge that the counter hits 1 wins, and the sequence advances.
- Not defined:
  - WAIT_READY waits indefinitely and TIMEOUT_CYCLES is unused.
  - FAULT is reachable only through a ready drop in DONE.

## Structure
- Shared package reset_sequencer_pkg holds:
  - the state encoding constants: DELAY, WAIT_READY, DONE, FAULT;
  - the counter-width function.
- One sub-module, reset_sequencer_timer: a loadable down-counter with a load value, enable and an at-one flag. It serves both the settle delay and the timeout.

## Test plan
Parameters: STAGE_COUNT=3, STAGE_DELAY=4, TIMEOUT_CYCLES=10.
- Reset release, each stage_ready tied high 1 cycle after its release:
  - reset_out goes 111 → 110 at edge 4 → 100 → 000.
  - Each release comes 4 edges after the previous stage's ready is sampled.
  - sequence_done rises 1 edge after stage 2 ready.
- stage_ready[1] withheld 7 cycles after release, with TIMEOUT_EN:
  - No fault.
  - reset_out[2] falls 4 edges after ready is sampled.
- stage_ready[1] never asserted, with TIMEOUT_EN:
  - fault=1 and reset_out=111, 10 cycles after reset_out[1] falls.
  - Without TIMEOUT_EN, the block stays in WAIT_READY for over 1000 cycles.
- In DONE, stage_ready[0] drops for 1 cycle:
  - fault=1, sequence_done=0, reset_out=111.
  - A 1-cycle restart then clears fault and reruns the full sequence.
- restart pulsed while stage 1 is in DELAY: all resets reassert next edge, and reset_out[0] falls 4 edges after restart falls.
- reset asserted mid-sequence, between clock edges: reset_out=111 and sequence_done=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and the
// width of the shared settle/timeout down-counter.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    DELAY      = 2'd0,
    WAIT_READY = 2'd1,
    DONE       = 2'd2,
    FAULT      = 2'd3
  } state_e;

  // Wide enough to hold the larger of the two reload values.
  function automatic int unsigned counter_width(input int unsigned settle,
                                                input int unsigned timeout);
    int unsigned largest;
    largest = (settle > timeout) ? settle : timeout;
    return $clog2(largest + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_timer.sv
// Loadable down-counter shared by the settle delay and the ready timeout.
// Load wins over enable; the count never goes below zero.
module reset_sequencer_timer #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned RESET_VALUE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             at_one
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: reload, decrement, or hold.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register, preset so the first settle delay starts out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= WIDTH'(RESET_VALUE);
    end else begin
      count_q <= count_d;
    end
  end

  assign at_one = (count_q == WIDTH'(1));

endmodule

// File: rtl/reset_sequencer.sv
// Releases STAGE_COUNT reset domains in order, each after a settle delay and
// only once the previous stage reports ready. All outputs are registered.
// Optional build macro: RESET_SEQUENCER_TIMEOUT_EN enables the ready timeout.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned STAGE_COUNT    = 4,
  parameter int unsigned STAGE_DELAY    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   restart,
  input  logic [STAGE_COUNT-1:0] stage_ready,
  output logic [STAGE_COUNT-1:0] reset_out,
  output logic                   sequence_done,
  output logic                   fault
);

  localparam int unsigned CW       = counter_width(STAGE_DELAY, TIMEOUT_CYCLES);
  localparam int unsigned IW       = (STAGE_COUNT > 1) ? $clog2(STAGE_COUNT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(STAGE_COUNT - 1);

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [STAGE_COUNT-1:0] reset_out_q, reset_out_d;
  logic                   done_q, done_d;
  logic                   fault_q, fault_d;

  logic                   timer_load;
  logic [CW-1:0]          timer_load_value;
  logic                   timer_enable;
  logic                   timer_at_one;

  reset_sequencer_timer #(
    .WIDTH       (CW),
    .RESET_VALUE (STAGE_DELAY)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_load_value),
    .enable     (timer_enable),
    .at_one     (timer_at_one)
  );

  // Next-state, stage index, timer control and next output values.
  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    reset_out_d      = reset_out_q;
    done_d           = done_q;
    fault_d          = fault_q;
    timer_load       = 1'b0;
    timer_load_value = CW'(STAGE_DELAY);
    timer_enable     = 1'b0;

    if (restart) begin
      // Same as reset, but synchronous; overrides every other transition.
      state_d     = DELAY;
      idx_d       = '0;
      reset_out_d = '1;
      done_d      = 1'b0;
      fault_d     = 1'b0;
      timer_load  = 1'b1;
    end else begin
      unique case (state_q)
        DELAY: begin
          if (timer_at_one) begin
            reset_out_d[idx_q] = 1'b0;
            state_d            = WAIT_READY;
            timer_load         = 1'b1;
            timer_load_value   = CW'(TIMEOUT_CYCLES);
          end else begin
            timer_enable = 1'b1;
          end
        end
        WAIT_READY: begin
          // Ready on the same edge as the timeout expiry still advances.
          if (stage_ready[idx_q]) begin
            if (idx_q == LAST_IDX) begin
              state_d = DONE;
            end else begin
              idx_d      = idx_q + IW'(1);
              state_d    = DELAY;
              timer_load = 1'b1;
            end
          end else begin
`ifdef RESET_SEQUENCER_TIMEOUT_EN
            if (timer_at_one) begin
              state_d     = FAULT;
              reset_out_d = '1;
              done_d      = 1'b0;
              fault_d     = 1'b1;
            end else begin
              timer_enable = 1'b1;
            end
`endif
          end
        end
        DONE: begin
          // done rises one edge after entry; any ready drop aborts.
          if (!(&stage_ready)) begin
            state_d     = FAULT;
            reset_out_d = '1;
            done_d      = 1'b0;
            fault_d     = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
        FAULT: begin
          reset_out_d = '1;
          done_d      = 1'b0;
          fault_d     = 1'b1;
        end
        default: begin
          state_d = FAULT;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= DELAY;
      idx_q       <= '0;
      reset_out_q <= '1;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      reset_out_q <= reset_out_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  assign reset_out     = reset_out_q;
  assign sequence_done = done_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with 3 stages, 4-cycle settle delay and
// 10-cycle timeout. Expectations follow RESET_SEQUENCER_TIMEOUT_EN if defined.
module tb_reset_sequencer;

  localparam int unsigned NS = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          restart;
  logic [NS-1:0] stage_ready;
  logic [NS-1:0] reset_out;
  logic          sequence_done;
  logic          fault;

  int n_checks = 0;
  int n_fail   = 0;

  reset_sequencer #(
    .STAGE_COUNT    (NS),
    .STAGE_DELAY    (4),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .restart       (restart),
    .stage_ready   (stage_ready),
    .reset_out     (reset_out),
    .sequence_done (sequence_done),
    .fault         (fault)
  );

  always #5 clock = ~clock;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Stimulus only: reset, release it, stop just after stage 0 is released.
  task automatic start_from_reset();
    reset       = 1'b1;
    restart     = 1'b0;
    stage_ready = '0;
    tick();
    tick();
    reset = 1'b0;
    repeat (4) tick();
  endtask

  // Stimulus only: raise ready[k] one cycle after its release, then wait for
  // the next release (or for done after the last stage).
  task automatic ready_stage(input int k);
    tick();
    stage_ready[k] = 1'b1;
    tick();
    if (k < NS - 1) repeat (4) tick();
    else tick();
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    restart     = 1'b0;
    stage_ready = '0;
    #1;
    n_checks++;
    if (reset_out !== 3'b111) begin
      n_fail++; $display("FAIL reset_out_in_reset: got %b want 111", reset_out);
    end
    n_checks++;
    if (sequence_done !== 1'b0 || fault !== 1'b0) begin
      n_fail++; $display("FAIL flags_in_reset: got done=%b fault=%b want 0 0", sequence_done, fault);
    end
    tick();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (reset_out !== 3'b111) begin
      n_fail++; $display("FAIL reset_out_edge3: got %b want 111", reset_out);
    end
    tick();
    n_checks++;
    if (reset_out !== 3'b110) begin
      n_fail++; $display("FAIL reset_out_edge4: got %b want 110", reset_out);
    end
  endtask

  // Continues from test_reset: stage 0 just released.
  task automatic test_normal_sequence();
    logic [NS-1:0] exp;
    exp = 3'b110;
    for (int k = 0; k < NS; k++) begin
      tick();
      stage_ready[k] = 1'b1;
      tick();
      if (k < NS - 1) begin
        repeat (3) tick();
        n_checks++;
        if (reset_out !== exp || sequence_done !== 1'b0) begin
          n_fail++;
          $display("FAIL hold_before_release%0d: got %b done=%b want %b done=0",
                   k + 1, reset_out, sequence_done, exp);
        end
        tick();
        exp[k+1] = 1'b0;
        n_checks++;
        if (reset_out !== exp) begin
          n_fail++; $display("FAIL release%0d: got %b want %b", k + 1, reset_out, exp);
        end
      end else begin
        n_checks++;
        if (sequence_done !== 1'b0 || reset_out !== 3'b000) begin
          n_fail++;
          $display("FAIL done_not_yet: got done=%b reset_out=%b want 0 000", sequence_done, reset_out);
        end
        tick();
        n_checks++;
        if (sequence_done !== 1'b1 || fault !== 1'b0) begin
          n_fail++; $display("FAIL done_rise: got done=%b fault=%b want 1 0", sequence_done, fault);
        end
      end
    end
  endtask

  task automatic test_withheld_ready();
    start_from_reset();
    ready_stage(0);
    repeat (7) tick();
    stage_ready[1] = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (fault !== 1'b0 || reset_out !== 3'b100) begin
      n_fail++; $display("FAIL withheld_no_fault: got fault=%b reset_out=%b want 0 100", fault, reset_out);
    end
    tick();
    n_checks++;
    if (reset_out !== 3'b100) begin
      n_fail++; $display("FAIL withheld_hold: got %b want 100", reset_out);
    end
    tick();
    n_checks++;
    if (reset_out !== 3'b000 || fault !== 1'b0) begin
      n_fail++; $display("FAIL withheld_release2: got %b fault=%b want 000 0", reset_out, fault);
    end
  endtask

  task automatic test_timeout();
    start_from_reset();
    ready_stage(0);
`ifdef RESET_SEQUENCER_TIMEOUT_EN
    repeat (9) tick();
    n_checks++;
    if (fault !== 1'b0 || reset_out !== 3'b100) begin
      n_fail++; $display("FAIL timeout_early: got fault=%b reset_out=%b want 0 100", fault, reset_out);
    end
    tick();
    n_checks++;
    if (fault !== 1'b1 || reset_out !== 3'b111 || sequence_done !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_fault: got fault=%b reset_out=%b done=%b want 1 111 0",
               fault, reset_out, sequence_done);
    end
    stage_ready = 3'b111;
    repeat (5) tick();
    n_checks++;
    if (fault !== 1'b1 || reset_out !== 3'b111) begin
      n_fail++; $display("FAIL timeout_sticky: got fault=%b reset_out=%b want 1 111", fault, reset_out);
    end
`else
    repeat (1100) tick();
    n_checks++;
    if (fault !== 1'b0 || reset_out !== 3'b100 || sequence_done !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_forever: got fault=%b reset_out=%b done=%b want 0 100 0",
               fault, reset_out, sequence_done);
    end
`endif
  endtask

  task automatic test_done_drop();
    start_from_reset();
    ready_stage(0);
    ready_stage(1);
    ready_stage(2);
    n_checks++;
    if (sequence_done !== 1'b1 || reset_out !== 3'b000) begin
      n_fail++; $display("FAIL drop_pre_done: got done=%b reset_out=%b want 1 000", sequence_done, reset_out);
    end
    stage_ready[0] = 1'b0;
    tick();
    stage_ready[0] = 1'b1;
    n_checks++;
    if (fault !== 1'b1 || sequence_done !== 1'b0 || reset_out !== 3'b111) begin
      n_fail++;
      $display("FAIL drop_fault: got fault=%b done=%b reset_out=%b want 1 0 111",
               fault, sequence_done, reset_out);
    end
    tick();
    n_checks++;
    if (fault !== 1'b1 || reset_out !== 3'b111) begin
      n_fail++; $display("FAIL drop_sticky: got fault=%b reset_out=%b want 1 111", fault, reset_out);
    end
    restart     = 1'b1;
    stage_ready = '0;
    tick();
    restart = 1'b0;
    n_checks++;
    if (fault !== 1'b0 || reset_out !== 3'b111 || sequence_done !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_clear: got fault=%b reset_out=%b done=%b want 0 111 0",
               fault, reset_out, sequence_done);
    end
    repeat (3) tick();
    n_checks++;
    if (reset_out !== 3'b111) begin
      n_fail++; $display("FAIL rerun_hold: got %b want 111", reset_out);
    end
    tick();
    n_checks++;
    if (reset_out !== 3'b110) begin
      n_fail++; $display("FAIL rerun_release0: got %b want 110", reset_out);
    end
    ready_stage(0);
    ready_stage(1);
    ready_stage(2);
    n_checks++;
    if (sequence_done !== 1'b1 || reset_out !== 3'b000 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL rerun_done: got done=%b reset_out=%b fault=%b want 1 000 0",
               sequence_done, reset_out, fault);
    end
  endtask

  task automatic test_restart_in_delay();
    start_from_reset();
    tick();
    stage_ready[0] = 1'b1;
    tick();
    tick();
    n_checks++;
    if (reset_out !== 3'b110) begin
      n_fail++; $display("FAIL stage1_delay: got %b want 110", reset_out);
    end
    restart = 1'b1;
    tick();
    n_checks++;
    if (reset_out !== 3'b111 || fault !== 1'b0) begin
      n_fail++; $display("FAIL restart_assert: got %b fault=%b want 111 0", reset_out, fault);
    end
    stage_ready = '0;
    tick();
    restart = 1'b0;
    n_checks++;
    if (reset_out !== 3'b111) begin
      n_fail++; $display("FAIL restart_held: got %b want 111", reset_out);
    end
    repeat (3) tick();
    n_checks++;
    if (reset_out !== 3'b111) begin
      n_fail++; $display("FAIL restart_settle: got %b want 111", reset_out);
    end
    tick();
    n_checks++;
    if (reset_out !== 3'b110) begin
      n_fail++; $display("FAIL restart_release0: got %b want 110", reset_out);
    end
  endtask

  task automatic test_async_reset();
    start_from_reset();
    ready_stage(0);
    ready_stage(1);
    ready_stage(2);
    n_checks++;
    if (sequence_done !== 1'b1) begin
      n_fail++; $display("FAIL async_pre_done: got %b want 1", sequence_done);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (reset_out !== 3'b111 || sequence_done !== 1'b0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got reset_out=%b done=%b fault=%b want 111 0 0",
               reset_out, sequence_done, fault);
    end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal_sequence();
    test_withheld_ready();
    test_timeout();
    test_done_drop();
    test_restart_in_delay();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
